ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver and the successor to the single-byte scancode receiver. It adds input synchronisation, a configurable clock glitch filter, full frame checking (start, parity, stop), a watchdog that resynchronises on partial frames, and optional E0/F0 prefix folding. Decoded key events are buffered in a FIFO with a valid/ready handshake toward the CPU I/O block. It sits between the board PS/2 pins and the memory-mapped keyboard port.

---
 rtl/ps2_rx_fifo.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with input synchronisers, clock glitch filter,
// start/parity/stop checking, partial-frame watchdog, optional E0/F0 prefix
// folding and a show-ahead event FIFO with a valid/ready consumer handshake.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int DECODE_PREFIX  = 1
) (
    input  logic                          CLOCK_50,
    input  logic                          rst_n,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DAT,
    output logic [7:0]                    event_code,
    output logic                          event_ext,
    output logic                          event_break,
    output logic                          event_valid,
    input  logic                          event_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FULL_LVL = FW'(FIFO_DEPTH);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYCLES - 1);

    logic [1:0]            clk_sync;
    logic [1:0]            dat_sync;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_state;
    logic                  fall_edge;

    logic [3:0]            bit_cnt;
    logic [9:0]            frame_bits;
    logic [WW-1:0]         wd_cnt;
    logic                  timeout_hit;

    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  ext_flag;
    logic                  brk_flag;
    logic                  prefix_byte;
    logic                  push_req;
    logic [9:0]            push_word;

    logic [9:0]            mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [FW-1:0]         fill;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  do_pop;
    logic                  do_push;
    logic [9:0]            head_word;

    // Two-flop synchronisers; both pins idle high so reset them high
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
        end
    end

    // Glitch filter: state only flips once the whole sample window agrees
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            filt_sr    <= '1;
            filt_state <= 1'b1;
            fall_edge  <= 1'b0;
        end else begin
            filt_sr   <= {filt_sr[FILTER_LEN-2:0], clk_sync[1]};
            fall_edge <= 1'b0;
            if (&filt_sr) begin
                filt_state <= 1'b1;
            end else if (filt_sr == '0) begin
                filt_state <= 1'b0;
                fall_edge  <= filt_state;
            end
        end
    end

    assign timeout_hit = (bit_cnt != 4'd0) && !fall_edge && (wd_cnt == WD_LIMIT);

    // Bit capture, frame checks on the 11th edge, and partial-frame watchdog
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            bit_cnt    <= 4'd0;
            frame_bits <= '0;
            wd_cnt     <= '0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (fall_edge) begin
                wd_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (frame_bits[0] || !dat_sync[1]) begin
                        frame_err <= 1'b1;
                    end else if ((^frame_bits[9:1]) == 1'b0) begin
                        parity_err <= 1'b1;
                    end else begin
                        byte_valid <= 1'b1;
                        byte_data  <= frame_bits[8:1];
                    end
                end else begin
                    frame_bits[bit_cnt] <= dat_sync[1];
                    bit_cnt             <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt == 4'd0) begin
                wd_cnt <= '0;
            end else if (timeout_hit) begin
                bit_cnt   <= 4'd0;
                wd_cnt    <= '0;
                frame_err <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + WW'(1);
            end
        end
    end

    assign prefix_byte = (DECODE_PREFIX != 0) &&
                         ((byte_data == 8'hE0) || (byte_data == 8'hF0));
    assign push_req    = byte_valid && !prefix_byte;
    assign push_word   = (DECODE_PREFIX != 0) ? {byte_data, ext_flag, brk_flag}
                                              : {byte_data, 2'b00};

    // Prefix flags: set by E0/F0, consumed by the next real byte, dropped on timeout
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (timeout_hit) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (byte_valid && (DECODE_PREFIX != 0)) begin
            if (byte_data == 8'hE0) begin
                ext_flag <= 1'b1;
            end else if (byte_data == 8'hF0) begin
                brk_flag <= 1'b1;
            end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
        end
    end

    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == FULL_LVL);
    assign do_pop     = !fifo_empty && event_ready;
    assign do_push    = push_req && (!fifo_full || do_pop);

    // FIFO storage; contents need no reset because the head is gated by valid
    always_ff @(posedge CLOCK_50) begin
        if (do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                fill <= fill + FW'(1);
            end else if (!do_push && do_pop) begin
                fill <= fill - FW'(1);
            end
            if (push_req && fifo_full && !do_pop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

    assign head_word   = mem[rd_ptr];
    assign event_valid = !fifo_empty;
    assign event_code  = event_valid ? head_word[9:2] : 8'h00;
    assign event_ext   = event_valid & head_word[1];
    assign event_break = event_valid & head_word[0];
    assign fill_level  = fill;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: one instance folds prefixes, a second
// streams raw bytes; both share the PS/2 pins, reset and clr_err.
module tb_ps2_rx_fifo;

    localparam int HP    = 40;
    localparam int DEPTH = 8;

    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic rst_n, ps2_clk, ps2_dat, clr_err, ready_a, ready_b;

    logic [7:0] code_a, code_b;
    logic       ext_a, ext_b, brk_a, brk_b, valid_a, valid_b;
    logic [3:0] fill_a, fill_b;
    logic       par_a, par_b, frm_a, frm_b, ovf_a, ovf_b;

    ps2_rx_fifo #(.FILTER_LEN(8), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(600), .DECODE_PREFIX(1)) dut_a (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .event_code(code_a), .event_ext(ext_a), .event_break(brk_a), .event_valid(valid_a),
        .event_ready(ready_a), .fill_level(fill_a), .parity_err(par_a), .frame_err(frm_a),
        .overflow(ovf_a), .clr_err(clr_err));

    ps2_rx_fifo #(.FILTER_LEN(8), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(600), .DECODE_PREFIX(0)) dut_b (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .event_code(code_b), .event_ext(ext_b), .event_break(brk_b), .event_valid(valid_b),
        .event_ready(ready_b), .fill_level(fill_b), .parity_err(par_b), .frame_err(frm_b),
        .overflow(ovf_b), .clr_err(clr_err));

    int assert_cnt = 0;
    int fail_cnt   = 0;

    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic       exp_ovf = 1'b0;
    int         exp_par = 0;
    int         exp_frm = 0;
    int         par_cnt_a = 0, par_cnt_b = 0, frm_cnt_a = 0, frm_cnt_b = 0;
    int         ev_cnt_a = 0, ev_cnt_b = 0;
    int         base_a, base_b;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Consumer side: compare every popped head against the scoreboard
    always @(negedge CLOCK_50) begin
        if (valid_a && ready_a) begin
            if (exp_a.size() == 0) begin
                checkOutput("A unexpected event", 32'(valid_a), 32'd0);
            end else begin
                checkOutput("A event", 32'({code_a, ext_a, brk_a}), 32'(exp_a.pop_front()));
            end
            ev_cnt_a++;
        end
        if (valid_b && ready_b) begin
            if (exp_b.size() == 0) begin
                checkOutput("B unexpected event", 32'(valid_b), 32'd0);
            end else begin
                checkOutput("B event", 32'({code_b, ext_b, brk_b}), 32'(exp_b.pop_front()));
            end
            ev_cnt_b++;
        end
    end

    // Error pulse counters (one count per high cycle)
    always @(negedge CLOCK_50) begin
        if (par_a) par_cnt_a++;
        if (par_b) par_cnt_b++;
        if (frm_a) frm_cnt_a++;
        if (frm_b) frm_cnt_b++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge CLOCK_50);
        #2;
    endtask

    task automatic sendBit(input logic d, input logic glitch);
        ps2_dat = d;
        waitCycles(HP / 4);
        if (glitch) begin
            ps2_clk = 1'b0;
            waitCycles(1);
            ps2_clk = 1'b1;
        end
        waitCycles(HP / 4);
        ps2_clk = 1'b0;
        waitCycles(HP / 2);
        if (glitch) begin
            ps2_clk = 1'b1;
            waitCycles(1);
            ps2_clk = 1'b0;
        end
        waitCycles(HP / 2);
        ps2_clk = 1'b1;
    endtask

    task automatic sendBits(input logic [10:0] f, input int n, input logic glitch);
        for (int i = 0; i < n; i++) sendBit(f[i], glitch);
    endtask

    // Reference decoder and FIFO capacity model for a good byte
    task automatic modelByte(input logic [7:0] b);
        exp_b.push_back({b, 2'b00});
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (!ready_a && exp_a.size() >= DEPTH) exp_ovf = 1'b1;
            else exp_a.push_back({b, m_ext, m_brk});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic flip_par, input logic stop, input logic glitch);
        logic [10:0] f;
        f = {stop, (~^b) ^ flip_par, b, 1'b0};
        if (!stop) exp_frm++;
        else if (flip_par) exp_par++;
        else modelByte(b);
        sendBits(f, 11, glitch);
        waitCycles(100);
    endtask

    task automatic checkErrs(input string tag);
        checkOutput({tag, " parity A"}, 32'(par_cnt_a), 32'(exp_par));
        checkOutput({tag, " frame A"},  32'(frm_cnt_a), 32'(exp_frm));
        checkOutput({tag, " parity B"}, 32'(par_cnt_b), 32'(exp_par));
        checkOutput({tag, " frame B"},  32'(frm_cnt_b), 32'(exp_frm));
    endtask

    task automatic doReset();
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        rst_n   = 1'b0;
        waitCycles(5);
        rst_n   = 1'b1;
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        waitCycles(20);
    endtask

    initial begin
        clr_err = 1'b0;
        ready_a = 1'b0;
        ready_b = 1'b1;
        doReset();

        // Reset state
        checkOutput("reset valid", 32'(valid_a), 32'd0);
        checkOutput("reset fill", 32'(fill_a), 32'd0);
        checkOutput("reset code", 32'(code_a), 32'd0);
        checkOutput("reset overflow", 32'(ovf_a), 32'd0);
        checkOutput("reset err pulses", 32'({par_a, frm_a, par_b, frm_b}), 32'd0);

        // Single frame held in A's FIFO
        applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0);
        checkOutput("T1 valid", 32'(valid_a), 32'd1);
        checkOutput("T1 code", 32'(code_a), 32'h1C);
        checkOutput("T1 ext/brk", 32'({ext_a, brk_a}), 32'd0);
        checkOutput("T1 fill", 32'(fill_a), 32'd1);
        checkErrs("T1");
        ready_a = 1'b1;
        waitCycles(1);
        ready_a = 1'b0;
        waitCycles(2);
        checkOutput("T1 fill after pop", 32'(fill_a), 32'd0);

        // Prefix folding versus raw stream
        ready_a = 1'b1;
        base_a = ev_cnt_a;
        base_b = ev_cnt_b;
        applyStimulus(8'hE0, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'hF0, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h74, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0);
        checkOutput("T2 A event count", 32'(ev_cnt_a - base_a), 32'd2);
        checkOutput("T2 B event count", 32'(ev_cnt_b - base_b), 32'd4);

        // Parity and stop-bit errors
        ready_a = 1'b0;
        applyStimulus(8'h1C, 1'b1, 1'b1, 1'b0);
        checkOutput("T3 fill after parity err", 32'(fill_a), 32'd0);
        applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0);
        checkOutput("T3 fill after frame err", 32'(fill_a), 32'd0);
        checkErrs("T3");

        // Watchdog: pending E0 must be forgotten after a timed-out partial frame
        ready_a = 1'b1;
        applyStimulus(8'hE0, 1'b0, 1'b1, 1'b0);
        sendBits(11'h4D2, 5, 1'b0);
        waitCycles(6000);
        exp_frm++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        checkErrs("T4 timeout");
        applyStimulus(8'h29, 1'b0, 1'b1, 1'b0);
        checkErrs("T4 after");

        // Overflow with consumer stalled
        ready_a = 1'b0;
        for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 1'b0, 1'b1, 1'b0);
        checkOutput("T5 fill full", 32'(fill_a), 32'(exp_a.size()));
        checkOutput("T5 overflow", 32'(ovf_a), 32'(exp_ovf));
        checkOutput("T5 B overflow", 32'(ovf_b), 32'd0);
        base_a = ev_cnt_a;
        ready_a = 1'b1;
        waitCycles(20);
        ready_a = 1'b0;
        checkOutput("T5 popped", 32'(ev_cnt_a - base_a), 32'd8);
        checkOutput("T5 valid after drain", 32'(valid_a), 32'd0);
        checkOutput("T5 fill after drain", 32'(fill_a), 32'd0);
        clr_err = 1'b1;
        waitCycles(1);
        clr_err = 1'b0;
        exp_ovf = 1'b0;
        waitCycles(1);
        checkOutput("T5 overflow cleared", 32'(ovf_a), 32'(exp_ovf));

        // Glitch immunity, then reset in the middle of a frame
        ready_a = 1'b1;
        applyStimulus(8'h33, 1'b0, 1'b1, 1'b1);
        sendBits(11'h6B4, 6, 1'b0);
        doReset();
        applyStimulus(8'h5A, 1'b0, 1'b1, 1'b0);
        checkErrs("T6");

        checkOutput("A scoreboard drained", 32'(exp_a.size()), 32'd0);
        checkOutput("B scoreboard drained", 32'(exp_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
